// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared types and defaults for the framebuffer arbiter
package fb_arb_pkg;

    typedef enum logic {
        NORMAL     = 1'b0,
        FORCE_DRAW = 1'b1
    } arb_state_t;

    localparam int DEF_ADDR_W     = 19;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_RD_LAT     = 2;
    localparam int DEF_STARVE_MAX = 16;

    // Active frame size, used wherever a linear pixel address is computed
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

endpackage

// File: rtl/fb_arbiter_rd_valid_pipe.sv
// rtl/fb_arbiter_rd_valid_pipe.sv - valid shift register tracking reads in flight
module rd_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic clr,
    input  logic in_valid,
    output logic out_valid
);

    logic [DEPTH-1:0] stage_q;

    // Shift one bit per cycle; clearing drops every read still in flight
    always_ff @(posedge clk) begin
        if (clr) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[DEPTH-2:0], in_valid};
        end
    end

    assign out_valid = stage_q[DEPTH-1];

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - display-priority framebuffer arbiter with forced draw slot
module fb_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_wdata,
    output logic              draw_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] STV_LIMIT = 8'(STARVE_MAX);

    arb_state_t state_q, state_d;
    logic [7:0] stv_cnt, stv_d;
    logic [7:0] stv_inc;
    logic       pipe_tail;

    assign stv_inc = stv_cnt + 8'd1;

    // State and starvation counter registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= NORMAL;
            stv_cnt <= 8'd0;
        end else begin
            state_q <= state_d;
            stv_cnt <= stv_d;
        end
    end

    // Grant decision, forced-slot scheduling and counter update
    always_comb begin
        disp_gnt = 1'b0;
        draw_gnt = 1'b0;
        state_d  = NORMAL;
        stv_d    = stv_cnt;
        if (!reset) begin
            case (state_q)
                NORMAL: begin
                    if (disp_req) begin
                        disp_gnt = 1'b1;
                    end else if (draw_req) begin
                        draw_gnt = 1'b1;
                    end
                end
                FORCE_DRAW: draw_gnt = 1'b1;
                default:    draw_gnt = 1'b0;
            endcase
        end
        if (draw_gnt || !draw_req) begin
            stv_d = 8'd0;
        end else if (disp_gnt) begin
            if (stv_inc == STV_LIMIT) begin
                stv_d   = 8'd0;
                state_d = FORCE_DRAW;
            end else begin
                stv_d = stv_inc;
            end
        end
    end

    // Issue register: the winner's access reaches memory one cycle after grant
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (disp_gnt) begin
            mem_addr <= disp_addr;
            mem_we   <= 1'b0;
        end else if (draw_gnt) begin
            mem_addr  <= draw_addr;
            mem_we    <= 1'b1;
            mem_wdata <= draw_wdata;
        end else begin
            mem_we <= 1'b0;
        end
    end

    rd_valid_pipe #(
        .DEPTH(RD_LAT + 1)
    ) u_rd_valid_pipe (
        .clk      (CLOCK_50),
        .clr      (reset),
        .in_valid (disp_gnt),
        .out_valid(pipe_tail)
    );

    // Masking with reset keeps a read due in the reset cycle from pulsing
    assign disp_rvalid = pipe_tail & ~reset;
    assign disp_rdata  = mem_rdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - scoreboard bench for fb_arbiter
module tb_fb_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              draw_req;
    logic [ADDR_W-1:0] draw_addr;
    logic [DATA_W-1:0] draw_wdata;
    logic              draw_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    typedef struct {
        int         due;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t    sb[$];
    logic [7:0] mem_store[int];
    logic [7:0] exp_mem[int];
    logic [7:0] rd_p1 = 8'h00;
    logic [7:0] rd_p2 = 8'h00;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    fb_arbiter dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_gnt   (disp_gnt),
        .disp_rvalid(disp_rvalid),
        .disp_rdata (disp_rdata),
        .draw_req   (draw_req),
        .draw_addr  (draw_addr),
        .draw_wdata (draw_wdata),
        .draw_gnt   (draw_gnt),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic logic [7:0] init_pat(input int a);
        logic [31:0] v;
        v = a;
        return v[7:0] ^ v[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_rd(input int a);
        return mem_store.exists(a) ? mem_store[a] : init_pat(a);
    endfunction

    function automatic logic [7:0] exp_rd(input int a);
        return exp_mem.exists(a) ? exp_mem[a] : init_pat(a);
    endfunction

    // Memory model with two cycles of read latency from mem_addr
    always @(posedge CLOCK_50) begin
        rd_p1 <= mem_rd(int'(mem_addr));
        rd_p2 <= rd_p1;
        if (mem_we === 1'b1) mem_store[int'(mem_addr)] = mem_wdata;
    end
    assign mem_rdata = rd_p2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every read-data strobe must match the oldest expected read
    always @(negedge CLOCK_50) begin
        if (disp_rvalid !== 1'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", 32'(disp_rvalid), 32'd0);
            end else begin
                rd_exp_t e;
                e = sb.pop_front();
                check("rvalid_cycle", 32'(cyc), 32'(e.due));
                check("rdata", 32'(disp_rdata), 32'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_read(input int a);
        rd_exp_t e;
        e.due  = cyc + 3;
        e.data = exp_rd(a);
        sb.push_back(e);
    endtask

    task automatic disp_read(input int a);
        disp_req  = 1'b1;
        draw_req  = 1'b0;
        disp_addr = ADDR_W'(a);
        @(negedge CLOCK_50);
        check("read_disp_gnt", 32'(disp_gnt), 32'd1);
        check("read_draw_gnt", 32'(draw_gnt), 32'd0);
        if (disp_gnt === 1'b1) push_read(a);
        step();
    endtask

    // Both requesters held high; exactly one draw grant expected at force_at
    task automatic contend(input int n, input int force_at, input int base);
        int da;
        da = base;
        disp_req = 1'b1;
        draw_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            disp_addr  = ADDR_W'(da);
            draw_addr  = ADDR_W'(32'h40000 + k);
            draw_wdata = 8'(k + 8'h80);
            @(negedge CLOCK_50);
            check("cont_draw_gnt", 32'(draw_gnt), 32'(k == force_at || k == force_at + 17));
            check("cont_disp_gnt", 32'(disp_gnt), 32'(!(k == force_at || k == force_at + 17)));
            check("cont_exclusive", 32'(disp_gnt & draw_gnt), 32'd0);
            if (disp_gnt === 1'b1) begin
                push_read(da);
                da++;
            end
            if (draw_gnt === 1'b1) exp_mem[32'h40000 + k] = 8'(k + 8'h80);
            step();
        end
    endtask

    initial begin
        reset      = 1'b1;
        disp_req   = 1'b1;
        draw_req   = 1'b1;
        disp_addr  = '0;
        draw_addr  = ADDR_W'(7);
        draw_wdata = 8'h11;

        // Reset with both requests pending
        repeat (3) begin
            @(negedge CLOCK_50);
            check("rst_disp_gnt", 32'(disp_gnt), 32'd0);
            check("rst_draw_gnt", 32'(draw_gnt), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_rvalid", 32'(disp_rvalid), 32'd0);
            step();
        end
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("first_disp_gnt", 32'(disp_gnt), 32'd1);
        check("first_draw_gnt", 32'(draw_gnt), 32'd0);
        if (disp_gnt === 1'b1) push_read(0);
        step();
        disp_req = 1'b0;
        @(negedge CLOCK_50);
        check("pending_draw_gnt", 32'(draw_gnt), 32'd1);
        if (draw_gnt === 1'b1) exp_mem[7] = 8'h11;
        step();
        draw_req = 1'b0;
        step();

        // Single draw, then read it back
        draw_req   = 1'b1;
        draw_addr  = ADDR_W'(32'h12345);
        draw_wdata = 8'hA5;
        @(negedge CLOCK_50);
        check("draw_gnt", 32'(draw_gnt), 32'd1);
        check("draw_disp_gnt", 32'(disp_gnt), 32'd0);
        if (draw_gnt === 1'b1) exp_mem[32'h12345] = 8'hA5;
        step();
        draw_req = 1'b0;
        @(negedge CLOCK_50);
        check("issue_mem_addr", 32'(mem_addr), 32'h12345);
        check("issue_mem_we", 32'(mem_we), 32'd1);
        check("issue_mem_wdata", 32'(mem_wdata), 32'hA5);
        step();
        @(negedge CLOCK_50);
        check("idle_mem_we", 32'(mem_we), 32'd0);
        check("idle_mem_addr_hold", 32'(mem_addr), 32'h12345);
        step();
        disp_read(32'h12345);
        disp_req = 1'b0;
        @(negedge CLOCK_50);
        check("read_issue_addr", 32'(mem_addr), 32'h12345);
        check("read_issue_we", 32'(mem_we), 32'd0);
        step();
        repeat (3) step();

        // Back-to-back display burst
        for (int i = 0; i < 8; i++) disp_read(i);
        disp_req = 1'b0;
        repeat (4) step();

        // Sustained contention: forced draw slots at 16 and 33
        contend(40, 16, 32'h100);
        disp_req = 1'b0;
        draw_req = 1'b0;
        repeat (5) step();

        // Build up the starvation count, then reset right after a display grant
        disp_req = 1'b1;
        draw_req = 1'b1;
        draw_addr = ADDR_W'(32'h50000);
        for (int k = 0; k < 5; k++) begin
            disp_addr = ADDR_W'(32'h200 + k);
            @(negedge CLOCK_50);
            check("pre_rst_disp_gnt", 32'(disp_gnt), 32'd1);
            if (disp_gnt === 1'b1) push_read(32'h200 + k);
            step();
        end
        reset = 1'b1;
        while (sb.size() > 0 && sb[sb.size() - 1].due >= cyc) void'(sb.pop_back());
        repeat (2) begin
            @(negedge CLOCK_50);
            check("mid_rst_rvalid", 32'(disp_rvalid), 32'd0);
            check("mid_rst_gnt", 32'(disp_gnt | draw_gnt), 32'd0);
            step();
        end
        reset = 1'b0;
        contend(20, 16, 32'h300);
        disp_req = 1'b0;
        draw_req = 1'b0;

        // Drain outstanding reads with a bounded wait
        for (int w = 0; w < 20 && sb.size() > 0; w++) step();
        repeat (3) step();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
